sync_fifo_param: RTL



---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_mem.sv | 23 ++
 rtl/sync_fifo_param.sv | 106 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << res) < value) res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DATA_W x DEPTH simple dual-port storage: synchronous write, asynchronous read.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and optional first-word-fall-through output.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FWFT_OFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [clog2(DEPTH):0]    count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, underflow_q;
  logic              rd_ok, wr_ok;
  logic [DATA_W-1:0] mem_rd_data;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO can still take a write when a read frees a slot in the same cycle.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= wr_en && !wr_ok;
      underflow_q <= rd_en && !rd_ok;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  generate
    if (FWFT == FWFT_OFF) begin : g_std
      // Capture happens on the same edge as any write, so a full+read+write returns the old word.
      logic [DATA_W-1:0] data_q;
      always_ff @(posedge clk) begin
        if (reset) data_q <= '0;
        else if (rd_ok) data_q <= mem_rd_data;
      end
      assign data_out = data_q;
    end else begin : g_fwft
      assign data_out = empty ? '0 : mem_rd_data;
    end
  endgenerate

endmodule
